// File: rtl/synth_env_pkg.sv
`default_nettype none
// ============================================================================
// Module      : synth_env_pkg
// Description : Shared envelope state encoding and sizing constants.
// Revision    : 1.0 - initial release
// ============================================================================
package synth_env_pkg;

    typedef enum logic [1:0] {
        ENV_IDLE    = 2'd0,
        ENV_ATTACK  = 2'd1,
        ENV_SUSTAIN = 2'd2,
        ENV_RELEASE = 2'd3
    } env_state_t;

    localparam logic [1:0] MAX_ATTEN = 2'd3;
    localparam int         ENV_CNT_W = 8;

endpackage
`default_nettype wire

// File: rtl/env_rate_counter.sv
`default_nettype none
// ============================================================================
// Module      : env_rate_counter
// Description : Counts envelope ticks and flags a step at the terminal count.
// Revision    : 1.0 - initial release
// ============================================================================
module env_rate_counter
    import synth_env_pkg::*;
#(
    parameter int CNT_W = ENV_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             tick_en,
    input  logic             step_en,
    input  logic [CNT_W-1:0] terminal,
    output logic             step
);

    logic [CNT_W-1:0] r_cnt;

    // Ticks keep counting even when steps are not enabled; only a step wraps to 0.
    assign step = tick_en && step_en && (r_cnt == terminal);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (tick_en) begin
            r_cnt <= step ? '0 : r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/envelope_shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : envelope_shift_ctrl
// Description : Attack/sustain/release envelope feeding aligned sample and
//               shift controls to the downstream arithmetic shifter.
// Revision    : 1.0 - initial release
// ============================================================================
module envelope_shift_ctrl
    import synth_env_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int ATTACK_TICKS  = 4,
    parameter int RELEASE_TICKS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             note_on,
    input  logic             note_off,
    input  logic             env_tick,
    input  logic [1:0]       boost,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_in_valid,
    output logic [WIDTH-1:0] sample_out,
    output logic             sample_out_valid,
    output logic [1:0]       distance,
    output logic             direction,
    output logic [1:0]       env_state
);

    localparam logic [ENV_CNT_W-1:0] c_attack_term  = ENV_CNT_W'(ATTACK_TICKS - 1);
    localparam logic [ENV_CNT_W-1:0] c_release_term = ENV_CNT_W'(RELEASE_TICKS - 1);

    env_state_t           r_state;
    env_state_t           w_next_state;
    logic [1:0]           r_level;
    logic [1:0]           w_next_level;
    logic                 w_step;
    logic                 w_step_en;
    logic                 w_clear;
    logic [ENV_CNT_W-1:0] w_terminal;

    assign w_step_en  = (r_state == ENV_ATTACK) || (r_state == ENV_RELEASE);
    assign w_terminal = (r_state == ENV_ATTACK) ? c_attack_term : c_release_term;
    assign w_clear    = (w_next_state != r_state);

    env_rate_counter #(
        .CNT_W (ENV_CNT_W)
    ) u_rate_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (w_clear),
        .tick_en  (env_tick),
        .step_en  (w_step_en),
        .terminal (w_terminal),
        .step     (w_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ENV_IDLE;
            r_level <= MAX_ATTEN;
        end else begin
            r_state <= w_next_state;
            r_level <= w_next_level;
        end
    end

    // Note events are checked before steps, so a coinciding step is dropped.
    always_comb begin
        w_next_state = r_state;
        w_next_level = r_level;
        case (r_state)
            ENV_IDLE: begin
                if (note_on) begin
                    w_next_state = ENV_ATTACK;
                    w_next_level = MAX_ATTEN;
                end
            end
            ENV_ATTACK: begin
                if (note_off) begin
                    w_next_state = ENV_RELEASE;
                end else if (w_step) begin
                    if (r_level <= 2'd1) begin
                        w_next_level = 2'd0;
                        w_next_state = ENV_SUSTAIN;
                    end else begin
                        w_next_level = r_level - 2'd1;
                    end
                end
            end
            ENV_SUSTAIN: begin
                w_next_level = 2'd0;
                if (note_off) begin
                    w_next_state = ENV_RELEASE;
                end
            end
            ENV_RELEASE: begin
                if (note_on) begin
                    w_next_state = ENV_ATTACK;
                end else if (w_step) begin
                    if (r_level == MAX_ATTEN) begin
                        w_next_state = ENV_IDLE;
                    end else begin
                        w_next_level = r_level + 2'd1;
                    end
                end
            end
            default: begin
                w_next_state = ENV_IDLE;
                w_next_level = MAX_ATTEN;
            end
        endcase
    end

    // Shift controls are taken from the pre-edge envelope so they line up with the sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_out       <= '0;
            sample_out_valid <= 1'b0;
            distance         <= MAX_ATTEN;
            direction        <= 1'b1;
        end else begin
            sample_out_valid <= sample_in_valid;
            if (sample_in_valid) begin
                sample_out <= (r_state == ENV_IDLE) ? '0 : sample_in;
                if ((r_state == ENV_SUSTAIN) && (boost != 2'd0)) begin
                    direction <= 1'b0;
                    distance  <= boost;
                end else begin
                    direction <= 1'b1;
                    distance  <= r_level;
                end
            end
        end
    end

    assign env_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_envelope_shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_envelope_shift_ctrl
// Description : Directed self-checking bench for envelope_shift_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_envelope_shift_ctrl;

    logic        clk;
    logic        rst_n;
    logic        note_on;
    logic        note_off;
    logic        env_tick;
    logic [1:0]  boost;
    logic [15:0] sample_in;
    logic        sample_in_valid;
    logic [15:0] sample_out;
    logic        sample_out_valid;
    logic [1:0]  distance;
    logic        direction;
    logic [1:0]  env_state;

    int checks;
    int errors;

    envelope_shift_ctrl #(
        .WIDTH         (16),
        .ATTACK_TICKS  (2),
        .RELEASE_TICKS (3)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .note_on          (note_on),
        .note_off         (note_off),
        .env_tick         (env_tick),
        .boost            (boost),
        .sample_in        (sample_in),
        .sample_in_valid  (sample_in_valid),
        .sample_out       (sample_out),
        .sample_out_valid (sample_out_valid),
        .distance         (distance),
        .direction        (direction),
        .env_state        (env_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // One env_tick strobe followed by three quiet clocks (tick every 4 clk).
    task automatic pulse_tick();
        env_tick = 1'b1;
        cycle();
        env_tick = 1'b0;
        repeat (3) cycle();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) pulse_tick();
    endtask

    task automatic check_ctl(input string name, input logic [1:0] exp_st,
                             input logic [1:0] exp_dist, input logic exp_dir);
        checks++;
        if (env_state !== exp_st || distance !== exp_dist || direction !== exp_dir) begin
            errors++;
            $display("FAIL %s: state=%0d dist=%0d dir=%0d, expected state=%0d dist=%0d dir=%0d",
                     name, env_state, distance, direction, exp_st, exp_dist, exp_dir);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; note_on = 0; note_off = 0; env_tick = 0; boost = 0;
        sample_in = 16'h4000; sample_in_valid = 1'b1;
        repeat (3) cycle();
        checks++;
        if (sample_out !== 16'h0000) begin
            errors++; $display("FAIL reset_sample: got %h expected 0000", sample_out);
        end
        checks++;
        if (sample_out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b expected 0", sample_out_valid);
        end
        check_ctl("reset_ctl", 2'd0, 2'd3, 1'b1);
        rst_n = 1'b1;
        cycle();
        checks++;
        if (sample_out !== 16'h0000 || sample_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL idle_sample: got %h/%b expected 0000/1", sample_out, sample_out_valid);
        end
    endtask

    task automatic test_attack();
        note_on = 1'b1;
        cycle();
        note_on = 1'b0;
        cycle();
        checks++;
        if (sample_out !== 16'h4000) begin
            errors++; $display("FAIL attack_sample: got %h expected 4000", sample_out);
        end
        check_ctl("attack_l3", 2'd1, 2'd3, 1'b1);
        ticks(2);
        check_ctl("attack_l2", 2'd1, 2'd2, 1'b1);
        ticks(1);
        check_ctl("attack_mid_step", 2'd1, 2'd2, 1'b1);
        ticks(1);
        check_ctl("attack_l1", 2'd1, 2'd1, 1'b1);
        ticks(2);
        check_ctl("sustain_l0", 2'd2, 2'd0, 1'b1);
    endtask

    task automatic test_boost();
        boost = 2'd2;
        cycle();
        check_ctl("boost2", 2'd2, 2'd2, 1'b0);
        boost = 2'd0;
        cycle();
        check_ctl("boost0", 2'd2, 2'd0, 1'b1);
    endtask

    task automatic test_release();
        note_off = 1'b1;
        cycle();
        note_off = 1'b0;
        cycle();
        check_ctl("release_l0", 2'd3, 2'd0, 1'b1);
        ticks(3);
        check_ctl("release_l1", 2'd3, 2'd1, 1'b1);
        ticks(3);
        check_ctl("release_l2", 2'd3, 2'd2, 1'b1);
        ticks(3);
        check_ctl("release_l3", 2'd3, 2'd3, 1'b1);
        checks++;
        if (sample_out !== 16'h4000) begin
            errors++; $display("FAIL release_sample: got %h expected 4000", sample_out);
        end
        ticks(3);
        check_ctl("release_idle", 2'd0, 2'd3, 1'b1);
        checks++;
        if (sample_out !== 16'h0000) begin
            errors++; $display("FAIL idle_mute: got %h expected 0000", sample_out);
        end
    endtask

    task automatic test_retrigger();
        note_on = 1'b1; cycle(); note_on = 1'b0;
        ticks(6);
        note_off = 1'b1; cycle(); note_off = 1'b0;
        ticks(6);
        check_ctl("pre_retrig_l2", 2'd3, 2'd2, 1'b1);
        note_on = 1'b1; cycle(); note_on = 1'b0;
        cycle();
        check_ctl("retrig_held_l2", 2'd1, 2'd2, 1'b1);
        note_on = 1'b1; cycle(); note_on = 1'b0;
        cycle();
        check_ctl("attack_ignores_on", 2'd1, 2'd2, 1'b1);
        ticks(2);
        check_ctl("retrig_l1", 2'd1, 2'd1, 1'b1);
        ticks(1);
        // note_off lands on the would-be step tick: release wins, level stays 1
        note_off = 1'b1; env_tick = 1'b1;
        cycle();
        note_off = 1'b0; env_tick = 1'b0;
        cycle();
        check_ctl("off_beats_step", 2'd3, 2'd1, 1'b1);
    endtask

    task automatic test_back_to_back();
        note_on = 1'b1; cycle(); note_on = 1'b0;
        ticks(2);
        check_ctl("b2b_sustain", 2'd2, 2'd0, 1'b1);
        note_on = 1'b1; note_off = 1'b1;
        cycle();
        note_on = 1'b0; note_off = 1'b0;
        cycle();
        check_ctl("b2b_off_wins", 2'd3, 2'd0, 1'b1);
        ticks(3);
        check_ctl("b2b_release_l1", 2'd3, 2'd1, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (sample_out !== 16'h0000 || sample_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_data: got %h/%b expected 0000/0", sample_out, sample_out_valid);
        end
        check_ctl("async_reset_ctl", 2'd0, 2'd3, 1'b1);
        cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_attack();
        test_boost();
        test_release();
        test_retrigger();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
